// File: rtl/isa_io_cycle_pkg.sv
// Shared definitions for the ISA I/O cycle engine and the DSP init sequencers.
// Latency: none (types and constants only).
// Backpressure: n/a.
package isa_io_cycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CMD     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    // Sound Blaster DSP register offsets from the card base address.
    localparam logic [3:0] DSP_RESET_OFS  = 4'h6;
    localparam logic [3:0] DSP_READ_OFS   = 4'hA;
    localparam logic [3:0] DSP_WRITE_OFS  = 4'hC;
    localparam logic [3:0] DSP_STATUS_OFS = 4'hE;

    // Byte returned to the sequencer when IOCHRDY never came back.
    localparam logic [7:0] TIMEOUT_READ_BYTE = 8'hFF;

    function automatic logic [15:0] dsp_port(input logic [15:0] base, input logic [3:0] ofs);
        return base + {12'h000, ofs};
    endfunction

endpackage

// File: rtl/isa_io_cycle_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Latency: q updates on the sys_clock edge after count_en / reset_n.
// Backpressure: none; holds at all-ones instead of wrapping.
//   sys_clock : clock
//   reset_n   : synchronous clear, active low (wins over count_en)
//   count_en  : advance by one this edge
//   q         : current count
module isa_io_cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clock,
    input  logic             reset_n,
    input  logic             count_en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            q <= '0;
        end else if (count_en && (q != {WIDTH{1'b1}})) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/isa_io_cycle.sv
// Runs one 8-bit ISA I/O read or write per request: BALE, IOR#/IOW#, IOCHRDY wait states.
// Latency: request to cycle_done = 1 + CMD_TICKS + RECOVERY_TICKS bus ticks plus IOCHRDY extension.
// Backpressure: requester holds cycle_req and operands until cycle_done; IOCHRDY low stretches the strobe.
//   sys_clock/reset/bus_clock : clock, sync active-high reset, tick enable
//   cycle_req/address/data_dir/data_out : request from the sequencer
//   data_in/cycle_done/timeout : completion status back to the sequencer
//   isa_* : ISA bus pins
module isa_io_cycle
    import isa_io_cycle_pkg::*;
#(
    parameter int CMD_TICKS      = 4,
    parameter int RECOVERY_TICKS = 1,
    parameter int TIMEOUT_TICKS  = 64
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        bus_clock,
    input  logic        cycle_req,
    input  logic [15:0] address,
    input  logic        data_dir,
    input  logic [15:0] data_out,
    output logic [15:0] data_in,
    output logic        cycle_done,
    output logic        timeout,
    output logic [15:0] isa_sa,
    output logic [7:0]  isa_sd_out,
    output logic        isa_sd_oe,
    input  logic [7:0]  isa_sd_in,
    output logic        isa_bale,
    output logic        isa_aen,
    output logic        isa_ior_n,
    output logic        isa_iow_n,
    input  logic        isa_iochrdy
);

    // The counter holds "ticks already spent in this state", so the final
    // tick of a state is the one where it equals the length minus one.
    localparam logic [7:0] CMD_LAST = 8'(CMD_TICKS - 1);
    localparam logic [7:0] REC_LAST = 8'(RECOVERY_TICKS - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_TICKS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  tick_cnt;
    logic        cnt_clear_n;
    logic        cap_write;
    logic        to_flag;
    logic [7:0]  rd_byte;
    logic        unused_data_hi;

    assign unused_data_hi = ^data_out[15:8];

    // Restart the tick count on every state change so each state times itself.
    assign cnt_clear_n = !(reset || (bus_clock && (state_nxt != state)));

    isa_io_cycle_counter #(.WIDTH(8)) u_tick_cnt (
        .sys_clock (sys_clock),
        .reset_n   (cnt_clear_n),
        .count_en  (bus_clock),
        .q         (tick_cnt)
    );

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (bus_clock) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cycle_req) state_nxt = ST_ADDR;
            ST_ADDR:    state_nxt = ST_CMD;
            ST_CMD:     if (tick_cnt == CMD_LAST) state_nxt = isa_iochrdy ? ST_RECOVER : ST_WAIT;
            ST_WAIT:    if (isa_iochrdy || (tick_cnt == TO_LAST)) state_nxt = ST_RECOVER;
            ST_RECOVER: if (tick_cnt == REC_LAST) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        isa_bale  = 1'b0;
        isa_aen   = 1'b1;
        isa_ior_n = 1'b1;
        isa_iow_n = 1'b1;
        isa_sd_oe = 1'b0;
        case (state)
            ST_ADDR: begin
                isa_bale = 1'b1;
                isa_aen  = 1'b0;
            end
            ST_CMD, ST_WAIT: begin
                isa_aen   = 1'b0;
                isa_ior_n = cap_write;
                isa_iow_n = !cap_write;
                isa_sd_oe = cap_write;
            end
            ST_RECOVER: begin
                isa_aen   = 1'b0;
                isa_sd_oe = cap_write;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            isa_sa     <= '0;
            isa_sd_out <= '0;
            cap_write  <= 1'b0;
            to_flag    <= 1'b0;
            rd_byte    <= '0;
            data_in    <= '0;
            cycle_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            timeout    <= 1'b0;
            if (bus_clock) begin
                case (state)
                    ST_IDLE: begin
                        if (cycle_req) begin
                            isa_sa     <= address;
                            isa_sd_out <= data_out[7:0];
                            cap_write  <= data_dir;
                            to_flag    <= 1'b0;
                        end
                    end
                    ST_CMD, ST_WAIT: begin
                        // Leaving WAIT with IOCHRDY still low can only be the expiry path.
                        if (state_nxt == ST_RECOVER) begin
                            if ((state == ST_WAIT) && !isa_iochrdy) begin
                                to_flag <= 1'b1;
                                rd_byte <= TIMEOUT_READ_BYTE;
                            end else begin
                                rd_byte <= isa_sd_in;
                            end
                        end
                    end
                    ST_RECOVER: begin
                        if (state_nxt == ST_IDLE) begin
                            cycle_done <= 1'b1;
                            timeout    <= to_flag;
                            if (!cap_write) begin
                                data_in <= {8'h00, rd_byte};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_isa_io_cycle.sv
module tb_isa_io_cycle;
    import isa_io_cycle_pkg::*;

    localparam int CMD_TICKS      = 4;
    localparam int RECOVERY_TICKS = 1;
    localparam int TIMEOUT_TICKS  = 64;

    typedef struct packed {
        logic [7:0]  bale_t;
        logic [7:0]  ior_t;
        logic [7:0]  iow_t;
        logic [7:0]  busy_t;
        logic [7:0]  oe_t;
        logic [15:0] sa;
        logic [7:0]  sdout;
        logic [15:0] din;
        logic        to;
        logic        rel;
    } obs_t;

    logic        sys_clock = 1'b0;
    logic        reset = 1'b1;
    logic        bus_clock = 1'b0;
    logic        cycle_req = 1'b0;
    logic [15:0] address = '0;
    logic        data_dir = 1'b0;
    logic [15:0] data_out = '0;
    logic [7:0]  isa_sd_in = '0;
    logic        isa_iochrdy = 1'b1;
    logic [15:0] data_in;
    logic        cycle_done;
    logic        timeout;
    logic [15:0] isa_sa;
    logic [7:0]  isa_sd_out;
    logic        isa_sd_oe;
    logic        isa_bale;
    logic        isa_aen;
    logic        isa_ior_n;
    logic        isa_iow_n;

    int          n_vec = 0;
    int          n_bad = 0;
    int          ext_cfg = 0;
    int          div = 0;
    logic [15:0] exp_din = '0;
    obs_t        done_q[$];
    int          gap_q[$];

    int          acc_bale, acc_ior, acc_iow, acc_busy, acc_oe, hi_run;
    logic [15:0] acc_sa;
    logic [7:0]  acc_sdout;

    isa_io_cycle #(
        .CMD_TICKS(CMD_TICKS), .RECOVERY_TICKS(RECOVERY_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .sys_clock(sys_clock), .reset(reset), .bus_clock(bus_clock),
        .cycle_req(cycle_req), .address(address), .data_dir(data_dir), .data_out(data_out),
        .data_in(data_in), .cycle_done(cycle_done), .timeout(timeout),
        .isa_sa(isa_sa), .isa_sd_out(isa_sd_out), .isa_sd_oe(isa_sd_oe), .isa_sd_in(isa_sd_in),
        .isa_bale(isa_bale), .isa_aen(isa_aen), .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n),
        .isa_iochrdy(isa_iochrdy)
    );

    always #10 sys_clock = ~sys_clock;

    // One-wide tick enable every 4th sys_clock, changed well clear of the edge.
    always @(posedge sys_clock) begin
        #2;
        div = (div + 1) % 4;
        bus_clock = (div == 0);
    end

    // Bus monitor: counts ticks per state-visible signal, one record per cycle_done.
    // It also plays the target: IOCHRDY goes high once the strobe has been low
    // CMD_TICKS + ext_cfg ticks.
    always @(negedge sys_clock) begin
        if (reset) begin
            acc_bale = 0; acc_ior = 0; acc_iow = 0; acc_busy = 0; acc_oe = 0; hi_run = 0;
            acc_sa = '0; acc_sdout = '0;
            isa_iochrdy = 1'b1;
        end else begin
            if (bus_clock) begin
                if (isa_bale)   acc_bale++;
                if (!isa_aen)   acc_busy++;
                if (isa_sd_oe)  acc_oe++;
                if (!isa_ior_n) acc_ior++;
                if (!isa_iow_n) acc_iow++;
                if (!isa_ior_n || !isa_iow_n) begin
                    if (acc_ior + acc_iow == 1) gap_q.push_back(hi_run);
                    hi_run = 0;
                end else begin
                    hi_run++;
                end
            end
            if (isa_bale)   acc_sa = isa_sa;
            if (!isa_iow_n) acc_sdout = isa_sd_out;
            if (cycle_done) begin
                done_q.push_back('{bale_t: 8'(acc_bale), ior_t: 8'(acc_ior), iow_t: 8'(acc_iow),
                                   busy_t: 8'(acc_busy), oe_t: 8'(acc_oe), sa: acc_sa,
                                   sdout: acc_sdout, din: data_in, to: timeout,
                                   rel: isa_ior_n & isa_iow_n & isa_aen & !isa_sd_oe});
                acc_bale = 0; acc_ior = 0; acc_iow = 0; acc_busy = 0; acc_oe = 0;
                acc_sa = '0; acc_sdout = '0;
            end
            isa_iochrdy = ((acc_ior + acc_iow) >= (CMD_TICKS + ext_cfg));
        end
    end

    // Reference: IOCHRDY low for ext samples starting at the last CMD tick.
    function automatic obs_t model(input logic dir, input logic [15:0] a, input logic [7:0] wd,
                                   input logic [7:0] sdin, input int ext, input logic [15:0] prev);
        obs_t e;
        bit   to_hit = (ext > TIMEOUT_TICKS);
        int   low = CMD_TICKS + (to_hit ? TIMEOUT_TICKS : ext);
        e.bale_t = 8'd1;
        e.ior_t  = dir ? 8'd0 : 8'(low);
        e.iow_t  = dir ? 8'(low) : 8'd0;
        e.busy_t = 8'(1 + low + RECOVERY_TICKS);
        e.oe_t   = dir ? 8'(low + RECOVERY_TICKS) : 8'd0;
        e.sa     = a;
        e.sdout  = dir ? wd : 8'h00;
        e.din    = dir ? prev : (to_hit ? 16'h00FF : {8'h00, sdin});
        e.to     = to_hit;
        e.rel    = 1'b1;
        return e;
    endfunction

    // Issue one request; inputs are scrambled and cycle_req dropped right after BALE.
    task automatic run_cycle(input logic [15:0] a, input logic dir, input logic [7:0] wd,
                             input logic [7:0] sdin, input int ext, output obs_t o, output bit got);
        @(posedge sys_clock); #1;
        address = a; data_dir = dir; data_out = {8'($urandom), wd};
        isa_sd_in = sdin; ext_cfg = ext; cycle_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clock); #1;
            if (isa_bale) break;
        end
        address = 16'($urandom); data_dir = !dir; data_out = 16'($urandom); cycle_req = 1'b0;
        for (int i = 0; i < 2000 && done_q.size() == 0; i++) @(posedge sys_clock);
        got = (done_q.size() != 0);
        o = got ? done_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge sys_clock);
        @(negedge sys_clock);
        n_vec++;
        if ({isa_ior_n, isa_iow_n, isa_bale, isa_aen, isa_sd_oe, cycle_done, timeout} !== 7'b1101000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want %b", {isa_ior_n, isa_iow_n, isa_bale, isa_aen,
                     isa_sd_oe, cycle_done, timeout}, 7'b1101000);
        end
        n_vec++;
        if ({isa_sa, isa_sd_out, data_in} !== 40'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want %h", {isa_sa, isa_sd_out, data_in}, 40'h0);
        end
        @(posedge sys_clock); #1;
        reset = 1'b0;
        exp_din = '0;
    endtask

    task automatic test_write_basic();
        obs_t o, e; bit got;
        run_cycle(16'h0226, 1'b1, 8'h01, 8'h5A, 0, o, got);
        e = model(1'b1, 16'h0226, 8'h01, 8'h5A, 0, exp_din);
        n_vec++;
        if (!got || o !== e) begin n_bad++; $display("FAIL write_basic: got %h want %h", o, e); end
        n_vec++;
        if (o.busy_t !== 8'd6 || o.iow_t !== 8'd4) begin
            n_bad++; $display("FAIL write_latency: got busy %0d iow %0d want 6 4", o.busy_t, o.iow_t);
        end
        exp_din = e.din;
    endtask

    task automatic test_read_basic();
        obs_t o, e; bit got;
        logic [15:0] a = dsp_port(16'h0220, DSP_STATUS_OFS);
        run_cycle(a, 1'b0, 8'h00, 8'h80, 0, o, got);
        e = model(1'b0, a, 8'h00, 8'h80, 0, exp_din);
        n_vec++;
        if (!got || o !== e) begin n_bad++; $display("FAIL read_basic: got %h want %h", o, e); end
        n_vec++;
        if (o.din !== 16'h0080 || o.oe_t !== 8'd0) begin
            n_bad++; $display("FAIL read_data: got %h oe %0d want 0080 0", o.din, o.oe_t);
        end
        exp_din = e.din;
    endtask

    task automatic test_read_extended();
        obs_t o, e; bit got;
        logic [15:0] a = dsp_port(16'h0220, DSP_READ_OFS);
        run_cycle(a, 1'b0, 8'h00, 8'hAA, 10, o, got);
        e = model(1'b0, a, 8'h00, 8'hAA, 10, exp_din);
        n_vec++;
        if (!got || o !== e) begin n_bad++; $display("FAIL read_ext: got %h want %h", o, e); end
        n_vec++;
        if (o.ior_t !== 8'd14 || o.din !== 16'h00AA || o.to !== 1'b0) begin
            n_bad++; $display("FAIL read_ext_len: got ior %0d din %h to %b want 14 00aa 0", o.ior_t, o.din, o.to);
        end
        exp_din = e.din;
    endtask

    task automatic test_timeout();
        obs_t o, e; bit got;
        logic [15:0] a = dsp_port(16'h0220, DSP_READ_OFS);
        run_cycle(a, 1'b0, 8'h00, 8'h55, 200, o, got);
        e = model(1'b0, a, 8'h00, 8'h55, 200, exp_din);
        n_vec++;
        if (!got || o !== e) begin n_bad++; $display("FAIL timeout: got %h want %h", o, e); end
        n_vec++;
        if (o.to !== 1'b1 || o.din !== 16'h00FF || o.ior_t !== 8'd68 || o.rel !== 1'b1) begin
            n_bad++; $display("FAIL timeout_flag: got to %b din %h ior %0d rel %b want 1 00ff 68 1",
                              o.to, o.din, o.ior_t, o.rel);
        end
        exp_din = e.din;
    endtask

    task automatic test_reset_mid_cycle();
        obs_t o, e; bit got; int i;
        @(posedge sys_clock); #1;
        address = dsp_port(16'h0220, DSP_WRITE_OFS); data_dir = 1'b1; data_out = 16'h00D1;
        ext_cfg = 0; cycle_req = 1'b1;
        i = 0;
        while (isa_iow_n && i < 200) begin @(posedge sys_clock); #1; i++; end
        cycle_req = 1'b0;
        @(posedge sys_clock); #1;
        reset = 1'b1;
        @(posedge sys_clock);
        @(negedge sys_clock);
        n_vec++;
        if (i >= 200 || {isa_iow_n, isa_aen, cycle_done} !== 3'b110) begin
            n_bad++; $display("FAIL reset_mid: got iow_n/aen/done %b (strobe wait %0d) want 110",
                              {isa_iow_n, isa_aen, cycle_done}, i);
        end
        @(posedge sys_clock); #1;
        reset = 1'b0;
        exp_din = '0;
        repeat (300) @(posedge sys_clock);
        n_vec++;
        if (done_q.size() != 0) begin
            n_bad++; $display("FAIL reset_mid_done: got %0d done pulses want 0", done_q.size());
        end
        done_q.delete();
        run_cycle(16'h0226, 1'b1, 8'hE1, 8'h00, 3, o, got);
        e = model(1'b1, 16'h0226, 8'hE1, 8'h00, 3, exp_din);
        n_vec++;
        if (!got || o !== e) begin n_bad++; $display("FAIL reset_recover: got %h want %h", o, e); end
        exp_din = e.din;
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [7:0]  vals [3] = '{8'h11, 8'h22, 8'h33};
        logic [15:0] a = dsp_port(16'h0220, DSP_STATUS_OFS);
        done_q.delete(); gap_q.delete();
        @(posedge sys_clock); #1;
        address = a; data_dir = 1'b0; data_out = 16'h0000; ext_cfg = 0;
        isa_sd_in = vals[0]; cycle_req = 1'b1;
        for (int g = 0; g < 3000 && done_q.size() < 3; g++) begin
            @(posedge sys_clock); #1;
            if (done_q.size() == 1) isa_sd_in = vals[1];
            if (done_q.size() == 2) isa_sd_in = vals[2];
        end
        cycle_req = 1'b0;
        repeat (100) @(posedge sys_clock);
        n_vec++;
        if (done_q.size() != 3 || gap_q.size() != 3) begin
            n_bad++; $display("FAIL b2b_count: got %0d done %0d strobes want 3 3", done_q.size(), gap_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                o = done_q.pop_front();
                e = model(1'b0, a, 8'h00, vals[k], 0, exp_din);
                n_vec++;
                if (o !== e) begin n_bad++; $display("FAIL b2b_cycle%0d: got %h want %h", k, o, e); end
                exp_din = e.din;
                if (k > 0) begin
                    n_vec++;
                    if (gap_q[k] != RECOVERY_TICKS + 2) begin
                        n_bad++; $display("FAIL b2b_gap%0d: got %0d want %0d", k, gap_q[k], RECOVERY_TICKS + 2);
                    end
                end
            end
        end
        done_q.delete();
    endtask

    task automatic test_random();
        obs_t o, e; bit got;
        logic [3:0]  ofs [4] = '{DSP_RESET_OFS, DSP_READ_OFS, DSP_WRITE_OFS, DSP_STATUS_OFS};
        logic [15:0] a; logic dir; logic [7:0] wd, sd; int ext, r;
        for (int n = 0; n < 16; n++) begin
            dir = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 1) == 1) ? dsp_port(16'h0220, ofs[$urandom_range(0, 3)]) : 16'($urandom);
            wd  = 8'($urandom);
            sd  = 8'($urandom);
            r   = $urandom_range(0, 9);
            ext = (r == 0) ? 200 : (r < 4) ? 0 : $urandom_range(1, 20);
            run_cycle(a, dir, wd, sd, ext, o, got);
            e = model(dir, a, wd, sd, ext, exp_din);
            n_vec++;
            if (!got || o !== e) begin
                n_bad++; $display("FAIL random%0d: got %h want %h (dir %b ext %0d)", n, o, e, dir, ext);
            end
            exp_din = e.din;
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_extended();
        test_timeout();
        test_write_basic();
        test_reset_mid_cycle();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
